calc_port_issue_queue: RTL
==========================

Name: calc_port_issue_queue

Overview:
- Downstream stage of the per-port hold register in calc1. Consumes the registered command and operand pair it presents.
- Buffers accepted commands in a small in-order FIFO and issues each head entry to either the add/sub unit or the shift unit over a valid/ready handshake.
- Limits in-flight operations per port with a credit counter.
- Rejects illegal command codes with an immediate invalid response, so downstream units only ever see legal operations.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- MAX_OUT, 2: maximum issued-but-not-done operations for this port, 1..7.

Ports:
- c_clk  in  1  system clock; all state updates on rising edge.
- reset  in  7  reset vector. Only bit 1 is used: synchronous, active-high. Bits 2..7 are ignored.
- hold_prio_req  in  4  command from the hold stage; non-zero = command present this cycle.
- hold_data1  in  32  operand 1; valid whenever hold_prio_req is non-zero.
- hold_data2  in  32  operand 2; valid whenever hold_prio_req is non-zero.
- add_valid  out  1  head is an add/sub and is being offered.
- add_ready  in  1  add/sub unit accepts.
- shift_valid  out  1  head is a shift and is being offered.
- shift_ready  in  1  shift unit accepts.
- issue_cmd  out  4  head command code.
- issue_op1  out  32  head operand 1.
- issue_op2  out  32  head operand 2.
- unit_done  in  1  one-cycle pulse: one outstanding op from this port completed.
- inv_resp  out  2  2'b10 for one cycle on an illegal command, else 2'b00.
- q_count  out  clog2(DEPTH)+1  current FIFO occupancy.
- q_full  out  1  q_count == DEPTH.
- ovf_err  out  1  sticky: a legal command was dropped because the FIFO was full.

Behaviour:
- Inputs from the hold stage change on the falling edge; this block samples them on the rising edge (half-cycle path).
- Legal codes: 1 add, 2 sub, 5 shift left, 6 shift right. Code 0 = idle; nothing happens.
- Enqueue: hold_prio_req legal and not full -> push {cmd, data1, data2}. Enqueue is visible at the head no earlier than the next cycle; empty-to-issue latency is 1 cycle.
- Illegal non-zero code (3, 4, 7..15): not enqueued; inv_resp = 2'b10 on the following cycle for exactly one cycle. Back-to-back illegal codes give back-to-back pulses.
- Legal code while full: dropped, ovf_err set and held until reset; inv_resp unaffected.
  - Full with a pop in the same cycle is still "full": the command is dropped (no bypass).
- Issue eligibility: FIFO not empty AND outstanding < MAX_OUT.
  - Head cmd 1/2 -> add_valid = 1; head cmd 5/6 -> shift_valid = 1.
  - Never both valids at once; both are 0 when not eligible.
  - issue_cmd/op1/op2 always reflect the head entry; don't-care (hold last value) when empty.
- Handshake: once asserted, valid and payload stay stable until the matching ready. Pop occurs on valid && ready in the same cycle.
  - Ready without valid has no effect.
  - Issue is strictly in order; a stalled head blocks all later entries, including those for the other unit.
- Outstanding counter:
  - +1 on issue handshake; -1 on unit_done; both in the same cycle -> unchanged.
  - unit_done while outstanding == 0 is ignored; the counter saturates at 0.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- Reset (reset[1] == 1 at rising edge): FIFO emptied, outstanding = 0, add_valid = shift_valid = 0, inv_resp = 2'b00, ovf_err = 0, q_count = 0, q_full = 0; input commands that cycle are discarded.
  - A reset in the middle of a handshake drops the offer with no pop accounting.

Decomposition:
- Shared calc1 package holds:
  - command code constants (CMD_NOP = 0, CMD_ADD = 1, CMD_SUB = 2, CMD_SHL = 5, CMD_SHR = 6)
  - response codes (RESP_NONE = 0, RESP_OK = 1, RESP_INV = 2)
  - an is_legal/is_shift decode function
- One sub-module, calc_sync_fifo: parameterised width/depth synchronous FIFO with count/full/empty. The top level owns decode, routing, credits and the error response.

Test Plan:
- Reset, then cmd 1 with data1 = 0x0000_0005, data2 = 0x0000_0003, add_ready = 1 -> add_valid for 1 cycle carrying cmd 1/5/3; q_count returns to 0; shift_valid stays 0.
- Cmd 3 then cmd 15 on consecutive cycles -> inv_resp = 2'b10 on two consecutive cycles; q_count stays 0; no valid asserted.
- Ready held low, 5 legal commands pushed (DEPTH = 4) -> q_full = 1 after the 4th; the 5th is dropped and ovf_err = 1; after releasing ready, exactly 4 issues occur in push order.
- MAX_OUT = 2, no unit_done, 3 queued adds with ready = 1 -> 2 issues, then add_valid = 0; one unit_done pulse -> the 3rd issues the next cycle.
- Queue shift (5) then add (1), shift_ready = 0, add_ready = 1 -> add_valid never asserts while the shift head stalls; raising shift_ready issues the shift, then the add.
- reset[1] pulsed while add_valid = 1 with 3 entries queued -> next cycle all outputs at reset values, ovf_err = 0, outstanding cleared (a later issue is not credit-blocked).

Source files
------------

// File: rtl/calc_port_issue_queue_pkg.sv
// calc1 shared package: command/response codes,
// issue-queue entry layout and command decode helpers.
package calc_port_issue_queue_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_INV  = 2'd2;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } iq_entry_t;

  localparam int ENTRY_W = $bits(iq_entry_t);

  function automatic logic is_legal(input logic [3:0] c);
    logic r;
    r = 1'b0;
    case (c)
      CMD_ADD, CMD_SUB,
      CMD_SHL, CMD_SHR: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_shift(input logic [3:0] c);
    return (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc_port_issue_queue_fifo.sv
// Synchronous in-order FIFO with occupancy count.
// Push while full and pop while empty are ignored.
module calc_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointers wrap naturally; count tracks push/pop balance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/calc_port_issue_queue.sv
// Per-port issue queue: buffers legal commands,
// issues in order to add or shift unit under credits.
module calc_port_issue_queue
  import calc_port_issue_queue_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int MAX_OUT = 2,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          c_clk,
  input  logic [7:1]    reset,
  input  logic [3:0]    hold_prio_req,
  input  logic [31:0]   hold_data1,
  input  logic [31:0]   hold_data2,
  output logic          add_valid,
  input  logic          add_ready,
  output logic          shift_valid,
  input  logic          shift_ready,
  output logic [3:0]    issue_cmd,
  output logic [31:0]   issue_op1,
  output logic [31:0]   issue_op2,
  input  logic          unit_done,
  output logic [1:0]    inv_resp,
  output logic [CW-1:0] q_count,
  output logic          q_full,
  output logic          ovf_err
);

  logic          rst;
  logic          unused_rst_bits;
  logic          cmd_legal;
  logic          cmd_illegal;
  logic          push;
  logic          pop;
  logic          empty;
  logic          eligible;
  logic          head_shift;
  logic          done_ok;
  iq_entry_t     in_ent;
  iq_entry_t     head;
  logic [2:0]    out_q;
  logic [1:0]    inv_q;
  logic          ovf_q;

  assign rst             = reset[1];
  assign unused_rst_bits = ^reset[7:2];

  assign cmd_legal   = is_legal(hold_prio_req);
  assign cmd_illegal = (hold_prio_req != CMD_NOP)
                    && !cmd_legal;
  assign push        = cmd_legal && !q_full && !rst;

  assign in_ent = '{cmd: hold_prio_req,
                    op1: hold_data1,
                    op2: hold_data2};

  calc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (c_clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_ent),
    .data_o  (head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (empty)
  );

  assign eligible   = !empty && (out_q < 3'(MAX_OUT));
  assign head_shift = is_shift(head.cmd);

  assign add_valid   = eligible && !head_shift;
  assign shift_valid = eligible && head_shift;
  assign issue_cmd   = head.cmd;
  assign issue_op1   = head.op1;
  assign issue_op2   = head.op2;

  assign pop = (add_valid && add_ready)
            || (shift_valid && shift_ready);

  assign done_ok = unit_done && (out_q != '0);

  // Credit counter: issues add, completions return.
  always_ff @(posedge c_clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (pop && !done_ok) begin
      out_q <= out_q + 3'd1;
    end else if (!pop && done_ok) begin
      out_q <= out_q - 3'd1;
    end
  end

  // Invalid-code pulse and sticky overflow flag.
  always_ff @(posedge c_clk) begin
    if (rst) begin
      inv_q <= RESP_NONE;
      ovf_q <= 1'b0;
    end else begin
      inv_q <= cmd_illegal ? RESP_INV : RESP_NONE;
      if (cmd_legal && q_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign inv_resp = inv_q;
  assign ovf_err  = ovf_q;

endmodule
